// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and sequencer for the
// single-port 8-bit data memory (synchronous write, registered read).
// Requester 0 is the core load/store path, requester 1 the loader/debug port.
// Each granted access takes three cycles: grant/command, memory access, response.
//
// Optional feature macro: DMEM_ARB_RANGE_CHECK_EN
//   defined   : addresses outside MEM_BASE..MEM_LAST are sequenced but never
//               reach the memory; the owner sees err=1 and rdata=0 with done.
//   undefined : addresses are forwarded unchecked and err0/err1 are tied to 0.
//
// state  | meaning
// IDLE   | no access in flight; requests sampled and arbitrated here
// ACCESS | command on the memory pins; the memory acts at the end of this cycle
// RESP   | read data present on mem_rdata; completion registered at cycle end

module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MEM_BASE = 64,
  parameter int MEM_LAST = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // An inverted address window is a configuration mistake; stop elaboration.
  if (MEM_LAST < MEM_BASE) begin : g_bad_window
    $error("dmem_arbiter: MEM_LAST is below MEM_BASE");
  end

  logic [1:0]        state;
  logic              last_gnt;   // requester granted most recently (1 = requester 1)
  logic              owner;      // requester owning the access in flight
  logic              own_we;     // access in flight is a write
  logic              own_bad;    // access in flight was rejected by the range check

  logic              any_req;
  logic              pick;       // requester chosen this cycle (1 = requester 1)
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cmd_ok;

  // Round-robin pick: a lone request wins outright, a tie goes to the
  // requester that was not granted last, so ties strictly alternate.
  always_comb begin
    any_req   = req0 | req1;
    pick      = (req0 && req1) ? ~last_gnt : req1;
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MEM_BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(MEM_LAST);
  assign cmd_ok = (sel_addr >= BASE_A) && (sel_addr <= LAST_A);
`else
  assign cmd_ok = 1'b1;
  assign err0   = 1'b0;
  assign err1   = 1'b0;
`endif

  // Sequencer: arbitrate in IDLE, drive the memory in ACCESS, complete in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      owner     <= 1'b0;
      own_we    <= 1'b0;
      own_bad   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
      err0      <= 1'b0;
      err1      <= 1'b0;
`endif
    end else begin
      // Grant, done and err are single-cycle pulses.
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
      err0  <= 1'b0;
      err1  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ACCESS;
            owner    <= pick;
            last_gnt <= pick;
            own_we   <= sel_we;
            own_bad  <= ~cmd_ok;
            gnt0     <= ~pick;
            gnt1     <= pick;
            // A rejected command leaves the memory pins alone so nothing
            // reaches the array; mem_we is already low in IDLE.
            if (cmd_ok) begin
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              mem_we    <= sel_we;
            end
          end
        end
        ACCESS: begin
          // The memory has sampled the command at this edge; the address
          // stays put so the registered read keeps returning the same word.
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (own_bad) begin
            rdata <= '0;
          end else if (!own_we) begin
            rdata <= mem_rdata;
          end
          done0 <= ~owner;
          done1 <= owner;
`ifdef DMEM_ARB_RANGE_CHECK_EN
          err0  <= own_bad & ~owner;
          err1  <= own_bad & owner;
`endif
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port 8-bit data memory (words 64..127, synchronous write, registered read when not writing). It sits between the data memory and two masters: requester 0 is the core load/store path and requester 1 is the loader/debug port. It serialises their accesses with round-robin fairness, drives the memory's address, write-data and write-enable pins, and returns read data with a completion pulse.

## Interface
Parameters:
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `MEM_BASE`, 64: lowest valid word address.
- `MEM_LAST`, 127: highest valid word address.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req0`, `req1`  in  1: access request from requester 0 or 1.
- `we0`, `we1`  in  1: 1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W: word address.
- `wdata0`, `wdata1`  in  DATA_W: write data.
- `gnt0`, `gnt1`  out  1: one-cycle grant pulse.
- `done0`, `done1`  out  1: one-cycle completion pulse.
- `err0`, `err1`  out  1: out-of-range flag, valid with `done`.
- `rdata`  out  DATA_W: read result, valid while a `done` is high.
- `mem_addr`  out  ADDR_W: to the data memory address pin.
- `mem_wdata`  out  DATA_W: to the data memory write-data pin.
- `mem_we`  out  1: to the data memory write-enable pin.
- `mem_rdata`  in  DATA_W: from the data memory read-data pin.

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: sample `req0` and `req1` at each edge.
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that is not `last_gnt`.
  - On a grant: latch that requester's `we`/`addr`/`wdata` into `mem_we`/`mem_addr`/`mem_wdata`, pulse the matching `gnt`, update `last_gnt`, go to ACCESS.
- ACCESS: the memory samples the command at the next edge. On that edge clear `mem_we` and go to RESP. `mem_addr` is held.
- RESP: on the next edge:
  - Reads: capture `mem_rdata` into `rdata`.
  - Writes: `rdata` is unchanged.
  - Pulse the owner's `done` and return to IDLE.
- Requests are ignored outside IDLE.
- Requester protocol:
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt`.
  - Deassert `req` within the cycle after `gnt`.
  - A `req` still high when the FSM is back in IDLE (the `done` cycle) is a new request.
- `last_gnt` resets to 1, so requester 0 wins the first tie. Ties strictly alternate, so neither requester can starve the other.
- Reset values:
  - State: IDLE.
  - All `gnt`, `done`, `err`: 0.
  - `rdata`, `mem_addr`, `mem_wdata`, `mem_we`: 0.
  - `last_gnt`: 1.
- Reset mid-operation:
  - Returns to IDLE on the reset edge; no `done` is issued.
  - The memory has no reset, so a write whose `mem_we` was high at that edge is committed.

## Timing
- Request sampled at edge E0:
  - `gnt` and the memory command are visible in cycle 1.
  - The memory acts at E1.
  - `done`, `rdata` and `err` are visible in cycle 3.
  - The earliest next grant is in cycle 4.
- Throughput: one access per 3 cycles.
- `mem_we` is high for exactly one cycle per write.
- `gnt0`/`gnt1` are never high together; neither are `done0`/`done1`.

## Configuration
- Macro: `DMEM_ARB_RANGE_CHECK_EN`.
- Defined:
  - An address outside `MEM_BASE`..`MEM_LAST` is still granted and sequenced with identical latency.
  - `mem_we` stays 0 and `mem_addr` keeps its previous value.
  - `rdata` is set to 0 and the owner's `err` is 1 with `done`.
- Not defined:
  - Addresses are forwarded unchecked.
  - `err0` and `err1` are constant 0.

## Test plan
- Reset: assert `rst_n`=0 for 2 cycles with both `req` high -> all outputs 0; no grant until the cycle after `rst_n`=1.
- Write then read:
  - `req0`, `we0`=1, `addr0`=70, `wdata0`=0xA5 -> `gnt0` cycle 1, `mem_we`=1 with `mem_addr`=70 cycle 1 only, `done0` cycle 3.
  - Then a read of 70 -> `rdata`=0xA5 with `done0`.
- Tie and fairness: `req0`/`req1` both high from reset and held -> grant order 0, 1, 0, 1, with grants 3 cycles apart.
- Requester 1 reads 100 while requester 0 writes 0x3C to 100 in the same IDLE cycle, after a prior `gnt1` -> write first, and the read returns 0x3C.
- Reset during ACCESS of a read -> no `done`, IDLE next cycle, all outputs 0.
- Range check:
  - With `DMEM_ARB_RANGE_CHECK_EN`: write to address 0x10 -> `done` with `err`=1, `mem_we` never 1.
  - Without it: `mem_addr`=0x10, `mem_we`=1, `err`=0.
